mtr_duty_ramp: RTL and testbench
================================

# mtr_duty_ramp

Two-channel duty sequencer that sits between the navigation/PID logic and the two 11-bit PWM generators driving the left and right motors. It accepts signed speed targets, slews each channel's duty magnitude toward its target by a fixed step once per PWM period, and forces a zero-duty dead-time before every direction reversal. Duty changes occur only at PWM period boundaries, so the PWM generators never see a glitched period.

## Interface

Parameters:
- STEP, 11'd32, duty change applied per PWM period per channel.
- DEAD_PERIODS, 4'd4, full PWM periods held at zero duty before a direction flip.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- en  in  1  drive enable; low forces both duties to 0.
- cmd_vld  in  1  one-cycle strobe that captures both speed targets.
- lft_spd  in  12  signed left target, two's complement.
- rght_spd  in  12  signed right target, two's complement.
- lft_duty  out  11  left PWM duty magnitude.
- rght_duty  out  11  right PWM duty magnitude.
- lft_rev  out  1  left direction; 1 = reverse.
- rght_rev  out  1  right direction; 1 = reverse.
- prd_strb  out  1  registered pulse, one cycle per PWM period.
- at_target  out  1  both channels settled at their targets.

## Operation

- Internal free-running 11-bit period counter `pcnt`:
  - Resets to 0 and increments every clk, so it stays aligned with the PWM generators' counters (same reset).
  - The boundary condition `bnd` is `pcnt == 11'h7FF`.
- Target capture:
  - On the cmd_vld edge, each speed is split into `tgt_rev` (the sign bit) and `tgt_mag` (|spd|).
  - -2048 saturates to magnitude 2047.
  - Targets persist until the next cmd_vld.
- Per-channel FSM, with states RUN and HOLD. Every FSM action happens only on a clock edge with `bnd` = 1, except the en-low override.
  - **RUN, no reversal pending** (`tgt_rev == cur_rev` or `tgt_mag == 0`):
    - `cur_mag` steps toward `tgt_mag` by STEP.
    - Clamp to `tgt_mag` on the final step; never overshoot.
    - Arithmetic is 12-bit, with no 11-bit wrap.
  - **RUN, reversal pending** (`tgt_rev != cur_rev` and `tgt_mag != 0`):
    - `cur_mag <= max(cur_mag - STEP, 0)`.
    - If that result is 0 (including when `cur_mag` is already 0), go to HOLD with `hold_cnt <= DEAD_PERIODS`.
  - **HOLD**:
    - `cur_mag` stays 0.
    - If the reversal is no longer pending, go to RUN with no flip.
    - Else if `hold_cnt == 0`, set `cur_rev <= tgt_rev` and go to RUN.
    - Else `hold_cnt <= hold_cnt - 1`.
- en low: on the next clk edge, regardless of `bnd`:
  - Both `cur_mag` go to 0 and both FSMs go to RUN with `hold_cnt` cleared.
  - `cur_rev` and the targets are retained.
  - When en returns, ramping restarts from 0 at boundaries, and a pending reversal goes through HOLD.
- Outputs:
  - `*_duty = cur_mag` and `*_rev = cur_rev`, taken directly from the registers.
  - prd_strb is high for the one cycle following each `bnd` edge.
  - at_target is registered every cycle. It is 1 iff both channels are in RUN with `cur_mag == tgt_mag` and (`cur_rev == tgt_rev` or `tgt_mag == 0`).

## Timing

- Reset values:
  - duties 0, rev 0, prd_strb 0, at_target 0.
  - `pcnt` 0, targets 0, state RUN, `hold_cnt` 0.
- The first boundary edge is the 2048th rising clk edge after rst_n deasserts. After that, boundaries repeat every 2048 clocks.
- Duty and rev update on the boundary edge (`pcnt` 2047→0), so the new value governs the entire next PWM period.
- Latency from cmd_vld to the first duty change is 1 to 2048 clocks.
- cmd_vld on the same edge as a boundary: that boundary still uses the old target, and the new target applies from the next boundary.
- Reversal timeline with magnitude hitting 0 at boundary k:
  - HOLD spans k+1 … k+DEAD_PERIODS.
  - rev flips at k+DEAD_PERIODS+1 with duty still 0.
  - The first nonzero duty appears at k+DEAD_PERIODS+2.
- rst_n assertion mid-ramp or mid-HOLD returns everything to reset values immediately (asynchronous).

## Test plan

- Reset, then cmd 100 → lft_duty goes 32, 64, 96, 100 on boundaries 1–4 (edges 2048, 4096, …); at_target rises on the cycle after boundary 4.
- Settled at +64, cmd −64 → duty 32 then 0, held at 0 for 4 boundaries, rev=1 at the next boundary, then 32, 64.
- cmd −2048 on rght_spd → rght_rev=1 after dead-time, rght_duty ramps in STEP increments to 2047 with no wrap.
- Ramping at 96, drop en → both duties 0 on the next clk mid-period. Re-raise en → ramp resumes from 0 at the next boundary.
- cmd_vld coincident with a boundary edge (+200 while settled at +64) → that boundary leaves duty at 64, next boundary gives 96.
- Mid-HOLD, cmd back to the original sign → channel returns to RUN at the next boundary with no rev toggle and ramps up.

Source files
------------

// File: rtl/mtr_duty_ramp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mtr_duty_ramp : two-channel PWM duty slew limiter with reversal dead-time  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mtr_duty_ramp #(
    parameter logic [10:0] STEP         = 11'd32,
    parameter logic [3:0]  DEAD_PERIODS = 4'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        cmd_vld,
    input  logic [11:0] lft_spd,
    input  logic [11:0] rght_spd,
    output logic [10:0] lft_duty,
    output logic [10:0] rght_duty,
    output logic        lft_rev,
    output logic        rght_rev,
    output logic        prd_strb,
    output logic        at_target
);
    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HOLD = 1'b1} state_t;

    logic [10:0]      pcnt_q;
    logic             bnd;
    logic             prd_strb_q;
    logic             at_target_q;
    logic [1:0][11:0] spd;
    logic [1:0][10:0] duty;
    logic [1:0]       rev;
    logic [1:0]       settled;

    assign spd = {rght_spd, lft_spd};
    assign bnd = (pcnt_q == 11'h7FF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q      <= 11'd0;
            prd_strb_q  <= 1'b0;
            at_target_q <= 1'b0;
        end else begin
            pcnt_q      <= pcnt_q + 11'd1;
            prd_strb_q  <= bnd;
            at_target_q <= &settled;
        end
    end

    for (genvar c = 0; c < 2; c++) begin : g_ch
        state_t      state_q;
        logic [3:0]  hold_cnt_q;
        logic [10:0] cur_mag_q;
        logic [10:0] tgt_mag_q;
        logic        cur_rev_q;
        logic        tgt_rev_q;
        logic        pend;
        logic [11:0] up_sum;
        logic [11:0] dn_diff;
        logic [10:0] spd_neg;
        logic [10:0] spd_abs;
        logic [10:0] ramp_mag;
        logic [10:0] dec_mag;

        // Sums are 12 bits wide so a step near full scale clamps instead of wrapping.
        always_comb begin
            pend     = (tgt_rev_q != cur_rev_q) && (tgt_mag_q != 11'd0);
            up_sum   = {1'b0, cur_mag_q} + {1'b0, STEP};
            dn_diff  = {1'b0, cur_mag_q} - {1'b0, STEP};
            dec_mag  = dn_diff[11] ? 11'd0 : dn_diff[10:0];
            ramp_mag = cur_mag_q;
            if (cur_mag_q < tgt_mag_q) begin
                ramp_mag = (up_sum >= {1'b0, tgt_mag_q}) ? tgt_mag_q : up_sum[10:0];
            end else if (cur_mag_q > tgt_mag_q) begin
                ramp_mag = (dn_diff[11] || (dn_diff[10:0] <= tgt_mag_q)) ? tgt_mag_q : dn_diff[10:0];
            end
            spd_neg = ~spd[c][10:0] + 11'd1;
            if (!spd[c][11])
                spd_abs = spd[c][10:0];
            else if (spd[c][10:0] == 11'd0)
                spd_abs = 11'h7FF;
            else
                spd_abs = spd_neg;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q    <= ST_RUN;
                hold_cnt_q <= 4'd0;
                cur_mag_q  <= 11'd0;
                tgt_mag_q  <= 11'd0;
                cur_rev_q  <= 1'b0;
                tgt_rev_q  <= 1'b0;
            end else begin
                if (cmd_vld) begin
                    tgt_rev_q <= spd[c][11];
                    tgt_mag_q <= spd_abs;
                end
                if (!en) begin
                    cur_mag_q  <= 11'd0;
                    state_q    <= ST_RUN;
                    hold_cnt_q <= 4'd0;
                end else if (bnd) begin
                    case (state_q)
                        ST_RUN: begin
                            if (pend) begin
                                cur_mag_q <= dec_mag;
                                if (dec_mag == 11'd0) begin
                                    state_q    <= ST_HOLD;
                                    hold_cnt_q <= DEAD_PERIODS;
                                end
                            end else begin
                                cur_mag_q <= ramp_mag;
                            end
                        end
                        ST_HOLD: begin
                            if (!pend) begin
                                state_q <= ST_RUN;
                            end else if (hold_cnt_q == 4'd0) begin
                                cur_rev_q <= tgt_rev_q;
                                state_q   <= ST_RUN;
                            end else begin
                                hold_cnt_q <= hold_cnt_q - 4'd1;
                            end
                        end
                        default: state_q <= ST_RUN;
                    endcase
                end
            end
        end

        assign duty[c]    = cur_mag_q;
        assign rev[c]     = cur_rev_q;
        assign settled[c] = (state_q == ST_RUN) && (cur_mag_q == tgt_mag_q) &&
                            ((cur_rev_q == tgt_rev_q) || (tgt_mag_q == 11'd0));
    end

    assign lft_duty  = duty[0];
    assign rght_duty = duty[1];
    assign lft_rev   = rev[0];
    assign rght_rev  = rev[1];
    assign prd_strb  = prd_strb_q;
    assign at_target = at_target_q;
endmodule
`default_nettype wire

// File: tb/tb_mtr_duty_ramp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mtr_duty_ramp : directed + randomized bench with a behavioural model    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_mtr_duty_ramp;
    localparam int C_STEP = 32;
    localparam int C_DEAD = 4;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        cmd_vld;
    logic [11:0] lft_spd;
    logic [11:0] rght_spd;
    logic [10:0] lft_duty;
    logic [10:0] rght_duty;
    logic        lft_rev;
    logic        rght_rev;
    logic        prd_strb;
    logic        at_target;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state, index 0 = left, 1 = right
    int m_pcnt;
    int m_mag[2];
    int m_rev[2];
    int m_hold[2];
    int m_hcnt[2];
    int t_rev[2];
    int t_mag[2];
    int m_strb;
    int m_at;

    mtr_duty_ramp #(.STEP(11'd32), .DEAD_PERIODS(4'd4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .cmd_vld   (cmd_vld),
        .lft_spd   (lft_spd),
        .rght_spd  (rght_spd),
        .lft_duty  (lft_duty),
        .rght_duty (rght_duty),
        .lft_rev   (lft_rev),
        .rght_rev  (rght_rev),
        .prd_strb  (prd_strb),
        .at_target (at_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int mag_of(input logic [11:0] s);
        int v;
        v = int'($signed(s));
        if (v == -2048) return 2047;
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        m_pcnt = 0;
        m_strb = 0;
        m_at   = 0;
        for (int c = 0; c < 2; c++) begin
            m_mag[c] = 0; m_rev[c] = 0; m_hold[c] = 0;
            m_hcnt[c] = 0; t_rev[c] = 0; t_mag[c] = 0;
        end
    endtask

    task automatic check_all();
        chk("lft_duty",  32'(lft_duty),  m_mag[0]);
        chk("rght_duty", 32'(rght_duty), m_mag[1]);
        chk("lft_rev",   32'(lft_rev),   m_rev[0]);
        chk("rght_rev",  32'(rght_rev),  m_rev[1]);
        chk("prd_strb",  32'(prd_strb),  m_strb);
        chk("at_target", 32'(at_target), m_at);
    endtask

    // One clock edge: advance the model from the inputs held across the edge.
    task automatic tick();
        int bnd;
        int pend;
        int nat;
        int diff;
        @(posedge clk);
        bnd = (m_pcnt == 2047);
        nat = 1;
        for (int c = 0; c < 2; c++)
            if (m_hold[c] != 0 || m_mag[c] != t_mag[c] ||
                (m_rev[c] != t_rev[c] && t_mag[c] != 0)) nat = 0;
        for (int c = 0; c < 2; c++) begin
            pend = (t_rev[c] != m_rev[c]) && (t_mag[c] != 0);
            if (!en) begin
                m_mag[c] = 0; m_hold[c] = 0; m_hcnt[c] = 0;
            end else if (bnd) begin
                if (m_hold[c] != 0) begin
                    if (!pend) m_hold[c] = 0;
                    else if (m_hcnt[c] == 0) begin m_rev[c] = t_rev[c]; m_hold[c] = 0; end
                    else m_hcnt[c]--;
                end else if (pend) begin
                    m_mag[c] = (m_mag[c] > C_STEP) ? m_mag[c] - C_STEP : 0;
                    if (m_mag[c] == 0) begin m_hold[c] = 1; m_hcnt[c] = C_DEAD; end
                end else begin
                    diff = t_mag[c] - m_mag[c];
                    if (diff > C_STEP) m_mag[c] += C_STEP;
                    else if (diff < -C_STEP) m_mag[c] -= C_STEP;
                    else m_mag[c] = t_mag[c];
                end
            end
        end
        if (cmd_vld) begin
            t_rev[0] = lft_spd[11];  t_mag[0] = mag_of(lft_spd);
            t_rev[1] = rght_spd[11]; t_mag[1] = mag_of(rght_spd);
        end
        m_at   = nat;
        m_strb = bnd;
        m_pcnt = (m_pcnt + 1) % 2048;
        #1;
        if (m_pcnt == 0 || m_pcnt == 1 || m_pcnt == 1000) check_all();
    endtask

    task automatic run_to_bnd();
        do tick(); while (m_pcnt != 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [11:0] l, input logic [11:0] r);
        lft_spd = l; rght_spd = r; cmd_vld = 1'b1;
        tick();
        cmd_vld = 1'b0;
    endtask

    int exp_d[9] = '{32, 0, 0, 0, 0, 0, 0, 32, 64};
    int exp_r[9] = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
    int ramp1[4] = '{32, 64, 96, 100};
    logic [11:0] rs;

    initial begin
        rst_n = 1'b0; en = 1'b0; cmd_vld = 1'b0; lft_spd = '0; rght_spd = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        en = 1'b1;

        // Ramp up to +100 on the left
        send(12'd100, 12'd0);
        for (int b = 0; b < 4; b++) begin
            run_to_bnd();
            chk("ramp_up", 32'(lft_duty), ramp1[b]);
        end
        chk("at_target_lag", 32'(at_target), 0);
        tick();
        chk("at_target_rise", 32'(at_target), 1);

        // Settle at +64, then reverse left to -64 and right to -2048
        send(12'd64, 12'd0);
        run_to_bnd();
        run_to_bnd();
        chk("settle_64", 32'(lft_duty), 64);
        send(-12'sd64, 12'h800);
        for (int b = 0; b < 9; b++) begin
            run_to_bnd();
            chk("rev_duty", 32'(lft_duty), exp_d[b]);
            chk("rev_flag", 32'(lft_rev), exp_r[b]);
        end
        chk("r_sat_rev", 32'(rght_rev), 1);
        chk("r_sat_duty", 32'(rght_duty), 96);

        // Enable drop mid-period
        ticks(500);
        en = 1'b0;
        tick();
        chk("en_low_l", 32'(lft_duty), 0);
        chk("en_low_r", 32'(rght_duty), 0);
        chk("en_low_rev", 32'(rght_rev), 1);
        ticks(100);
        en = 1'b1;
        run_to_bnd();
        chk("en_resume_l", 32'(lft_duty), 32);
        chk("en_resume_r", 32'(rght_duty), 32);
        run_to_bnd();

        // Command coincident with a boundary edge
        while (m_pcnt != 2047) tick();
        send(-12'sd200, 12'h800);
        chk("coinc_old", 32'(lft_duty), 64);
        run_to_bnd();
        chk("coinc_new", 32'(lft_duty), 96);

        // Reversal abandoned during HOLD
        send(12'd50, 12'h800);
        for (int b = 0; b < 4; b++) run_to_bnd();
        chk("hold_entered", 32'(lft_duty), 0);
        ticks(300);
        send(-12'sd50, 12'h800);
        run_to_bnd();
        chk("abort_rev", 32'(lft_rev), 1);
        chk("abort_duty", 32'(lft_duty), 0);
        run_to_bnd();
        chk("abort_ramp1", 32'(lft_duty), 32);
        run_to_bnd();
        chk("abort_ramp2", 32'(lft_duty), 50);

        // Randomized commands and enable glitches against the model
        for (int p = 0; p < 8; p++) begin
            ticks($urandom_range(0, 1500));
            rs = 12'($urandom);
            if ($urandom_range(0, 7) == 0) rs = 12'h800;
            send(rs, 12'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                en = 1'b0;
                ticks($urandom_range(1, 20));
                en = 1'b1;
            end
            run_to_bnd();
            run_to_bnd();
        end

        // Asynchronous reset between clock edges
        ticks(300);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #10;
        rst_n = 1'b1;
        ticks(5);
        chk("post_reset_duty", 32'(lft_duty), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
